// File: rtl/inv_sqrt_seed.sv
// Seed stage for fixed-point fast inverse square root: serial leading-one scan, then power-of-two scaled guess.
// Optional macro INV_SQRT_SEED_LUT_EN selects the base mantissa from a 4-entry table instead of ONE/SQRT_HALF.
module inv_sqrt_seed #(
    parameter int INT_WIDTH   = 12,
    parameter int FRACT_WIDTH = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [INT_WIDTH+FRACT_WIDTH-1:0] x,
    output logic [INT_WIDTH+FRACT_WIDTH-1:0] x_half,
    output logic [INT_WIDTH+FRACT_WIDTH-1:0] y0,
    output logic                             zero_in,
    output logic                             busy,
    output logic                             done
);
    localparam int W  = INT_WIDTH + FRACT_WIDTH;
    localparam int IW = (W > 1) ? $clog2(W) : 1;
    localparam int XW = 2 * W + 1;

    function automatic longint isqrt(input longint n);
        longint r;
        longint t;
        r = 0;
        for (int i = 30; i >= 0; i--) begin
            t = r | (longint'(1) << i);
            if (t * t <= n) r = t;
        end
        return r;
    endfunction

    // round(2^F / sqrt(num/den)) = (floor(2v) + 1) >> 1, with floor(2v) an integer square root
    function automatic int round_inv_sqrt(input int num, input int den);
        longint n2;
        n2 = ((longint'(4) << (2 * FRACT_WIDTH)) * longint'(den)) / longint'(num);
        return int'((isqrt(n2) + 1) >>> 1);
    endfunction

    localparam int ONE       = 1 << FRACT_WIDTH;
    localparam int SQRT_HALF = round_inv_sqrt(2, 1);

`ifdef INV_SQRT_SEED_LUT_EN
    localparam logic [W:0] LUT_00 = (W+1)'(round_inv_sqrt(5, 4));
    localparam logic [W:0] LUT_01 = (W+1)'(round_inv_sqrt(7, 4));
    localparam logic [W:0] LUT_10 = (W+1)'(round_inv_sqrt(5, 2));
    localparam logic [W:0] LUT_11 = (W+1)'(round_inv_sqrt(7, 2));
`else
    localparam logic [W:0] ONE_B       = (W+1)'(ONE);
    localparam logic [W:0] SQRT_HALF_B = (W+1)'(SQRT_HALF);
`endif

    typedef enum logic [1:0] {IDLE, SCAN, SCALE, DONE} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   x_q, x_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [IW-1:0]  p_q, p_d;
    logic           zf_q, zf_d;
    logic [W-1:0]   x_half_q, x_half_d;
    logic [W-1:0]   y0_q, y0_d;
    logic           zero_in_q, zero_in_d;
    logic           done_q, done_d;

    int             e;
    int             k;
    logic           r;
    logic [W:0]     b;
    logic [XW-1:0]  rnd;
    logic [XW-1:0]  wide;
    logic [W-1:0]   seed;
`ifdef INV_SQRT_SEED_LUT_EN
    logic           m;
`endif

    // Seed arithmetic from the leading-one position p: e = p - F = 2k + r
    always_comb begin
        e    = int'(p_q) - FRACT_WIDTH;
        k    = e >>> 1;
        r    = e[0];
        rnd  = '0;
        wide = '0;
        seed = '0;
`ifdef INV_SQRT_SEED_LUT_EN
        m = (p_q == '0) ? 1'b0 : x_q[p_q - IW'(1)];
        case ({r, m})
            2'b00:   b = LUT_00;
            2'b01:   b = LUT_01;
            2'b10:   b = LUT_10;
            default: b = LUT_11;
        endcase
`else
        b = r ? SQRT_HALF_B : ONE_B;
`endif
        if (k >= 0) begin
            if (k > 0) rnd = XW'(1) << (k - 1);
            wide = (XW'(b) + rnd) >> k;
        end else begin
            wide = XW'(b) << (-k);
        end
        if (wide[XW-1:W] != '0) seed = '1;
        else                    seed = wide[W-1:0];
        if (seed == '0) seed = W'(1);
    end

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        idx_d     = idx_q;
        p_d       = p_q;
        zf_d      = zf_q;
        x_half_d  = x_half_q;
        y0_d      = y0_q;
        zero_in_d = zero_in_q;
        done_d    = done_q;
        unique case (state_q)
            IDLE: begin
                done_d = 1'b0;
                if (start) begin
                    x_d     = x;
                    idx_d   = IW'(W - 1);
                    zf_d    = 1'b0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (x_q[idx_q]) begin
                    p_d     = idx_q;
                    state_d = SCALE;
                end else if (idx_q == '0) begin
                    zf_d    = 1'b1;
                    state_d = SCALE;
                end else begin
                    idx_d = idx_q - IW'(1);
                end
            end
            SCALE: begin
                done_d  = 1'b1;
                state_d = DONE;
                if (zf_q) begin
                    y0_d      = '1;
                    x_half_d  = '0;
                    zero_in_d = 1'b1;
                end else begin
                    y0_d      = seed;
                    x_half_d  = x_q >> 1;
                    zero_in_d = 1'b0;
                end
            end
            DONE: begin
                // done stays high here; IDLE clears it one edge after start drops
                if (!start) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            x_q       <= '0;
            idx_q     <= IW'(W - 1);
            p_q       <= '0;
            zf_q      <= 1'b0;
            x_half_q  <= '0;
            y0_q      <= '0;
            zero_in_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            idx_q     <= idx_d;
            p_q       <= p_d;
            zf_q      <= zf_d;
            x_half_q  <= x_half_d;
            y0_q      <= y0_d;
            zero_in_q <= zero_in_d;
            done_q    <= done_d;
        end
    end

    assign x_half  = x_half_q;
    assign y0      = y0_q;
    assign zero_in = zero_in_q;
    assign done    = done_q;
    assign busy    = (state_q == SCAN) || (state_q == SCALE);

endmodule

// File: tb/tb_inv_sqrt_seed.sv
// Randomized and directed bench for inv_sqrt_seed against a real-arithmetic reference model.
module tb_inv_sqrt_seed;
    localparam int   W     = 16;
    localparam int   F     = 4;
    localparam real  ONE_R = 16.0;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] x;
    logic [W-1:0] x_half;
    logic [W-1:0] y0;
    logic         zero_in;
    logic         busy;
    logic         done;

    int           checks;
    int           errors;
    logic [W-1:0] prev_y0;

    inv_sqrt_seed #(.INT_WIDTH(12), .FRACT_WIDTH(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .x       (x),
        .x_half  (x_half),
        .y0      (y0),
        .zero_in (zero_in),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Reference: y0 ~ round(b / 2^k) for x with leading one at bit p, e = p - F = 2k + r
    function automatic void model(input logic [W-1:0] xv, output logic [W-1:0] ey, output int elat);
        int     p;
        int     e;
        int     k;
        int     r;
        int     yi;
        real    b;
        real    yr;
`ifdef INV_SQRT_SEED_LUT_EN
        int     m;
        real    a;
`endif
        p = -1;
        for (int i = 0; i < W; i++) if (xv[i]) p = i;
        if (p < 0) begin
            ey   = '1;
            elat = W + 1;
        end else begin
            elat = W - p + 1;
            e = p - F;
            k = $rtoi($floor(e / 2.0));
            r = e - 2 * k;
`ifdef INV_SQRT_SEED_LUT_EN
            m = (p == 0) ? 0 : int'(xv[p-1]);
            a = (1.25 + 0.5 * m) * ((r != 0) ? 2.0 : 1.0);
            b = $floor(ONE_R / $sqrt(a) + 0.5);
`else
            b = (r != 0) ? $floor(0.70710678 * ONE_R + 0.5) : ONE_R;
`endif
            yr = b;
            if (k >= 0) for (int i = 0; i < k; i++) yr = yr / 2.0;
            else        for (int i = 0; i < -k; i++) yr = yr * 2.0;
            yi = $rtoi($floor(yr + 0.5));
            if (yi > (1 << W) - 1) yi = (1 << W) - 1;
            if (yi < 1) yi = 1;
            ey = W'(yi);
        end
    endfunction

    task automatic run_op(input logic [W-1:0] v, input int hold, input bit keep);
        logic [W-1:0] ey;
        int           elat;
        int           cnt;
        bit           seen;
        bit           stable;
        model(v, ey, elat);
        if (!keep) begin
            @(negedge clk); start = 1'b0;
            @(negedge clk);
        end
        x = v; start = 1'b1;
        @(posedge clk); #1;
        x = W'($urandom);
        cnt = 0; seen = 0;
        while (cnt < 40 && !seen) begin
            @(posedge clk); #1;
            cnt++;
            if (cnt == 1) begin
                check("busy_scan", 32'(busy), 32'd1);
                check("y0_hold_scan", 32'(y0), 32'(prev_y0));
            end
            if (done) seen = 1;
        end
        check("latency", 32'(cnt), 32'(elat));
        check("y0", 32'(y0), 32'(ey));
        check("x_half", 32'(x_half), 32'(v >> 1));
        check("zero_in", 32'(zero_in), 32'(v == '0));
        check("busy_done", 32'(busy), 32'd0);
        stable = 1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (!done || busy || y0 !== ey) stable = 0;
        end
        check("no_retrigger", 32'(stable), 32'd1);
        @(negedge clk); start = 1'b0;
        @(posedge clk); #1;
        check("done_after_drop", 32'(done), 32'd1);
        @(posedge clk); #1;
        check("done_cleared", 32'(done), 32'd0);
        $display("op x=0x%04h y0=0x%04h exp=0x%04h x_half=0x%04h lat=%0d exp_lat=%0d", v, y0, ey, x_half, cnt, elat);
        prev_y0 = ey;
    endtask

    initial begin
        logic [W-1:0] v;
        checks  = 0;
        errors  = 0;
        prev_y0 = '0;
        rst_n   = 1'b0;
        start   = 1'b0;
        x       = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_y0", 32'(y0), 32'd0);
        check("rst_x_half", 32'(x_half), 32'd0);
        check("rst_zero_in", 32'(zero_in), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk); rst_n = 1'b1;

        run_op(16'h0040, 0, 0);
        run_op(16'h0020, 2, 0);
        run_op(16'h0001, 0, 0);
        run_op(16'hFFFF, 1, 0);
        run_op(16'h0000, 0, 0);
        run_op(16'h0300, 40, 0);

        for (int n = 0; n < 24; n++) begin
            v = W'($urandom) >> $urandom_range(0, W - 1);
            run_op(v, $urandom_range(0, 3), 0);
        end

        // Reset in the middle of a scan, then restart with start already high
        @(negedge clk); x = 16'h0003; start = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_y0", 32'(y0), 32'd0);
        check("midrst_x_half", 32'(x_half), 32'd0);
        check("midrst_zero_in", 32'(zero_in), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        prev_y0 = '0;
        @(negedge clk); x = 16'h0100; rst_n = 1'b1;
        run_op(16'h0100, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
